// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared definitions for the UART FIFO pointer/flag controller.
// This file holds the default address width, the per-cycle operation
// encoding, and the decode helper that maps accepted requests onto it.
package uart_fifo_pkg;

    // Default register-file address width (depth = 2**width).
    localparam int FIFO_ADDR_WIDTH_DEF = 5;

    // Operation applied at a clock edge, derived from the accepted push/pop.
    typedef enum logic [1:0] {
        NOP      = 2'd0,
        PUSH     = 2'd1,
        POP      = 2'd2,
        PUSH_POP = 2'd3
    } fifo_op_t;

    // Map the accepted push/pop pair onto an operation.
    function automatic fifo_op_t decode_op(input logic push_ok, input logic pop_ok);
        fifo_op_t op;
        case ({push_ok, pop_ok})
            2'b10:   op = PUSH;
            2'b01:   op = POP;
            2'b11:   op = PUSH_POP;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/uart_fifo_ptr.sv
// uart_fifo_ptr: ADDR_WIDTH-bit wrapping pointer with an increment enable.
// The pointer wraps by natural binary rollover, with no compare-and-clear.
module uart_fifo_ptr
    import uart_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_ptr
);

    logic [ADDR_WIDTH-1:0] r_ptr;

    // Advance the pointer by one on each enabled edge.
    // NOTE: reset is in the sensitivity list so it acts without waiting for
    // a clock edge. State is assigned with <= so every flop samples pre-edge
    // values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + ADDR_WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: pointer, flag and occupancy controller for one UART FIFO
// register file (synchronous write, combinational FWFT read).
// Optional feature: define UART_FIFO_ERR_FLAGS_EN to add the sticky
// overflow/underflow flags and their err_clr input.
module uart_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
`ifdef UART_FIFO_ERR_FLAGS_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] C_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] C_LAST = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);

    logic [ADDR_WIDTH:0] r_count;
    logic                r_full;
    logic                r_empty;
    logic                w_push_ok;
    logic                w_pop_ok;
    fifo_op_t            w_op;

    // Accept requests against the registered flags and decode the operation.
    // A push into a full FIFO is allowed when a pop frees the head slot in
    // the same edge; a pop from an empty FIFO is always rejected (no bypass).
    // NOTE: every signal written here gets a value on every pass, so no
    // latch is inferred.
    always_comb begin
        w_push_ok = wr & (~r_full | rd);
        w_pop_ok  = rd & ~r_empty;
        w_op      = decode_op(w_push_ok, w_pop_ok);
    end

    // Write pointer: advances on every accepted push.
    uart_fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_push_ok),
        .o_ptr (w_addr)
    );

    // Read pointer: advances on every accepted pop.
    uart_fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_pop_ok),
        .o_ptr (r_addr)
    );

    // Occupancy and full/empty flags; PUSH_POP and NOP leave them unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            case (w_op)
                PUSH: begin
                    r_count <= r_count + C_ONE;
                    r_empty <= 1'b0;
                    r_full  <= (r_count == C_LAST);
                end
                POP: begin
                    r_count <= r_count - C_ONE;
                    r_full  <= 1'b0;
                    r_empty <= (r_count == C_ONE);
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

`ifdef UART_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_ovf_set = wr & r_full & ~rd;
    assign w_unf_set = rd & r_empty;

    // Sticky error flags: a set condition wins over err_clr in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~err_clr) | w_ovf_set;
            r_underflow <= (r_underflow & ~err_clr) | w_unf_set;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign w_en  = w_push_ok;
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: self-checking bench for uart_fifo_ctrl (ADDR_WIDTH=2).
// The bench supplies the register file itself, keeps a queue-based model of
// the FIFO contents, and compares every output on each falling edge.
// Define UART_FIFO_ERR_FLAGS_EN to also exercise the sticky error flags.
module tb_uart_fifo_ctrl;
    import uart_fifo_pkg::*;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr;
    logic          rd;
    logic [7:0]    wdata;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
`ifdef UART_FIFO_ERR_FLAGS_EN
    logic          err_clr;
    logic          overflow;
    logic          underflow;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
`endif

    // Register file driven by the controller.
    logic [7:0] mem [DEPTH];
    wire  [7:0] r_data = mem[r_addr];

    // Behavioural model: queue of stored words plus pointer totals mod depth.
    logic [7:0] q [$];
    int         m_wp = 0;
    int         m_rp = 0;
    bit         m_full;
    bit         m_empty;
    bit         m_push;
    bit         m_pop;
    fifo_op_t   m_op;
    int         sz;
    int         n_ops [4] = '{0, 0, 0, 0};

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_seq [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] fill    [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    uart_fifo_ctrl #(
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .rd        (rd),
`ifdef UART_FIFO_ERR_FLAGS_EN
        .err_clr   (err_clr),
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .w_en      (w_en),
        .w_addr    (w_addr),
        .r_addr    (r_addr),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_en) mem[w_addr] <= wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model update from the FIFO rules: pop the head first, then append.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_wp = 0;
            m_rp = 0;
`ifdef UART_FIFO_ERR_FLAGS_EN
            m_ovf = 1'b0;
            m_unf = 1'b0;
`endif
        end else begin
            m_full  = (q.size() == DEPTH);
            m_empty = (q.size() == 0);
            m_push  = wr && (!m_full || rd);
            m_pop   = rd && !m_empty;
            m_op    = m_push ? (m_pop ? PUSH_POP : PUSH) : (m_pop ? POP : NOP);
            n_ops[int'(m_op)]++;
`ifdef UART_FIFO_ERR_FLAGS_EN
            m_ovf = (m_ovf && !err_clr) || (wr && m_full && !rd);
            m_unf = (m_unf && !err_clr) || (rd && m_empty);
`endif
            if (m_op == POP || m_op == PUSH_POP) begin
                void'(q.pop_front());
                m_rp = (m_rp + 1) % DEPTH;
            end
            if (m_op == PUSH || m_op == PUSH_POP) begin
                q.push_back(wdata);
                m_wp = (m_wp + 1) % DEPTH;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        sz = q.size();
        check("count",  32'(count),  32'(sz));
        check("empty",  32'(empty),  32'(sz == 0));
        check("full",   32'(full),   32'(sz == DEPTH));
        check("w_addr", 32'(w_addr), 32'(m_wp));
        check("r_addr", 32'(r_addr), 32'(m_rp));
        check("w_en",   32'(w_en),   32'(wr && (sz < DEPTH || rd)));
        if (sz > 0) check("r_data", 32'(r_data), 32'(q[0]));
`ifdef UART_FIFO_ERR_FLAGS_EN
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
`endif
    end

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr    = w;
        rd    = r;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        wr    = 1'b0;
        rd    = 1'b0;
        wdata = 8'h00;
`ifdef UART_FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",  32'(count),  32'd0);
        check("rst_empty",  32'(empty),  32'd1);
        check("rst_full",   32'(full),   32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_r_addr", 32'(r_addr), 32'd0);
        reset = 1'b0;

        // Fill: four pushes.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, fill[i]);
            check("fill_w_addr", 32'(w_addr), 32'((i + 1) % 4));
            check("fill_count",  32'(count),  32'(i + 1));
            check("fill_empty",  32'(empty),  32'd0);
            check("fill_head",   32'(r_data), 32'h11);
        end
        check("fill_full", 32'(full), 32'd1);

        // Full, push without pop: rejected.
        wr = 1'b1; rd = 1'b0; wdata = 8'h55;
        #1;
        check("ovf_w_en", 32'(w_en), 32'd0);
        step(1'b1, 1'b0, 8'h55);
        check("ovf_count", 32'(count),  32'd4);
        check("ovf_head",  32'(r_data), 32'h11);
        check("ovf_full",  32'(full),   32'd1);
`ifdef UART_FIFO_ERR_FLAGS_EN
        check("ovf_flag", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
`endif

        // Full, push with pop: accepted as PUSH_POP.
        wr = 1'b1; rd = 1'b1; wdata = 8'h55;
        #1;
        check("pp_w_en", 32'(w_en), 32'd1);
        step(1'b1, 1'b1, 8'h55);
        check("pp_count",  32'(count),  32'd4);
        check("pp_full",   32'(full),   32'd1);
        check("pp_r_addr", 32'(r_addr), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("pp_seq", 32'(r_data), 32'(exp_seq[i]));
            step(1'b0, 1'b1, 8'h00);
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // Empty, push with pop: push only.
        step(1'b1, 1'b1, 8'h66);
        check("ep_count",  32'(count),  32'd1);
        check("ep_r_addr", 32'(r_addr), 32'd1);
        check("ep_head",   32'(r_data), 32'h66);
        step(1'b0, 1'b1, 8'h00);
        check("ep_empty", 32'(empty), 32'd1);

`ifdef UART_FIFO_ERR_FLAGS_EN
        // Pop from empty sets underflow; a set condition beats err_clr.
        step(1'b0, 1'b1, 8'h00);
        check("unf_flag", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        step(1'b0, 1'b1, 8'h00);
        check("unf_set_wins", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        check("unf_clr", 32'(underflow), 32'd0);
`endif

        // Interleaved push/pop through the pointer wrap.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 8'(8'hB0 + i));
            check("il_head", 32'(r_data), 32'(8'hB0 + i));
            step(1'b0, 1'b1, 8'h00);
        end
        check("il_empty",  32'(empty),  32'd1);
        check("il_count",  32'(count),  32'd0);
        check("il_w_addr", 32'(w_addr), 32'd0);
        check("il_r_addr", 32'(r_addr), 32'd0);

        // Randomized traffic: push-heavy, then pop-heavy, then balanced.
        for (int ph = 0; ph < 3; ph++) begin
            repeat (200) begin
`ifdef UART_FIFO_ERR_FLAGS_EN
                err_clr = ($urandom_range(0, 99) < 10);
`endif
                step($urandom_range(0, 99) < (ph == 0 ? 75 : (ph == 1 ? 25 : 50)),
                     $urandom_range(0, 99) < (ph == 0 ? 30 : (ph == 1 ? 75 : 50)),
                     8'($urandom));
            end
        end
`ifdef UART_FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif

        // Reset in the middle of a burst, between edges.
        for (int g = 0; g < 2 * DEPTH && !empty; g++) step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
        check("mid_count", 32'(count), 32'd3);
        wr = 1'b0; rd = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("ar_count",  32'(count),  32'd0);
        check("ar_empty",  32'(empty),  32'd1);
        check("ar_full",   32'(full),   32'd0);
        check("ar_w_addr", 32'(w_addr), 32'd0);
        check("ar_r_addr", 32'(r_addr), 32'd0);
`ifdef UART_FIFO_ERR_FLAGS_EN
        check("ar_overflow",  32'(overflow),  32'd0);
        check("ar_underflow", 32'(underflow), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 8'h77);
        check("post_rst_head", 32'(r_data), 32'h77);
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
